// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes,
// sequencer state type and the nibble-count helper.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_NEGA = 3'b010;
  localparam logic [2:0] OP_NEGB = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/alu.sv
// Existing 4-bit combinational ALU: arithmetic ops produce a carry,
// logical ops clear it; z and s describe the 4-bit result.
module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic [3:0] r,
  output logic       c,
  output logic       z,
  output logic       s
);

  logic [4:0] sum_s;

  // Operation select; bit 4 of sum_s is the carry (always 0 for logical ops)
  always_comb begin
    sum_s = 5'b0_0000;
    case (op)
      3'b000:  sum_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      3'b001:  sum_s = {1'b0, a} + 5'b0_0001 + {4'b0000, cin};
      3'b010:  sum_s = {1'b0, ~a} + 5'b0_0001 + {4'b0000, cin};
      3'b011:  sum_s = {1'b0, ~b} + 5'b0_0001 + {4'b0000, cin};
      3'b100:  sum_s = {1'b0, a & b};
      3'b101:  sum_s = {1'b0, a | b};
      3'b110:  sum_s = {1'b0, a ^ b};
      3'b111:  sum_s = {1'b0, ~a};
      default: sum_s = 5'b0_0000;
    endcase
  end

  assign r = sum_s[3:0];
  assign c = sum_s[4];
  assign z = (sum_s[3:0] == 4'b0000);
  assign s = sum_s[3];

endmodule

// File: rtl/alu_seq.sv
// Nibble-serial WIDTH-bit ALU sequencer around the 4-bit alu.
// Optional overflow flag port v is enabled by defining ALU_SEQ_OVF_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             s
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             v
`endif
);

  localparam int NIB  = nib_count(WIDTH);
  localparam int IDXW = (NIB > 2) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t           state_r;
  logic [IDXW-1:0]  idx_r;
  logic [2:0]       op_r;
  logic             cin_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r, acc_next_s;
  logic             carry_r, zacc_r;
  logic             busy_r, done_r, z_r, c_r, s_r;
  logic [WIDTH-1:0] r_r;

  logic [3:0] a_nib_s, b_nib_s, alu_a_s, alu_b_s, alu_r_s;
  logic [2:0] alu_op_s;
  logic       alu_cin_s, alu_c_s, alu_z_s, alu_s_s, arith_s, first_s;

  assign arith_s = (op_r[2] == 1'b0);
  assign first_s = (idx_r == {IDXW{1'b0}});
  assign a_nib_s = a_r[{idx_r, 2'b00} +: 4];
  assign b_nib_s = b_r[{idx_r, 2'b00} +: 4];

  // Map the latched op onto the per-nibble alu command; the upper nibbles of
  // INC/NEGA/NEGB become plain ADDs that propagate the nibble-0 carry
  always_comb begin
    alu_a_s  = a_nib_s;
    alu_b_s  = b_nib_s;
    alu_op_s = op_r;
    case (op_r)
      OP_INC, OP_NEGA, OP_NEGB: begin
        if (first_s) begin
          alu_op_s = op_r;
        end else begin
          alu_op_s = OP_ADD;
          alu_b_s  = 4'b0000;
          if (op_r == OP_INC) begin
            alu_a_s = a_nib_s;
          end else if (op_r == OP_NEGA) begin
            alu_a_s = ~a_nib_s;
          end else begin
            alu_a_s = ~b_nib_s;
          end
        end
      end
      default: alu_op_s = op_r;
    endcase
    if (!arith_s) begin
      alu_cin_s = 1'b0;
    end else if (first_s) begin
      alu_cin_s = cin_r;
    end else begin
      alu_cin_s = carry_r;
    end
  end

  alu u_alu (
    .a   (alu_a_s),
    .b   (alu_b_s),
    .cin (alu_cin_s),
    .op  (alu_op_s),
    .r   (alu_r_s),
    .c   (alu_c_s),
    .z   (alu_z_s),
    .s   (alu_s_s)
  );

  // Partial result with the current nibble merged in
  always_comb begin
    acc_next_s = acc_r;
    acc_next_s[{idx_r, 2'b00} +: 4] = alu_r_s;
  end

`ifdef ALU_SEQ_OVF_EN
  logic v_r;
  assign v = v_r;
`endif

  // Sequencer FSM; a start seen on the completing edge chains the next
  // operation directly, so a held start yields one result every NIB cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IDXW{1'b0}};
      op_r    <= 3'b000;
      cin_r   <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      zacc_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      r_r     <= {WIDTH{1'b0}};
      z_r     <= 1'b0;
      c_r     <= 1'b0;
      s_r     <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      v_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            cin_r   <= cin;
            a_r     <= a;
            b_r     <= b;
            idx_r   <= {IDXW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= alu_c_s;
          zacc_r  <= first_s ? alu_z_s : (zacc_r & alu_z_s);
          if (idx_r == LAST_IDX) begin
            r_r    <= acc_next_s;
            z_r    <= zacc_r & alu_z_s;
            c_r    <= arith_s & alu_c_s;
            s_r    <= alu_s_s;
`ifdef ALU_SEQ_OVF_EN
            v_r    <= arith_s & (alu_a_s[3] == alu_b_s[3]) & (alu_r_s[3] != alu_a_s[3]);
`endif
            done_r <= 1'b1;
            idx_r  <= {IDXW{1'b0}};
            if (start) begin
              op_r    <= op;
              cin_r   <= cin;
              a_r     <= a;
              b_r     <= b;
              busy_r  <= 1'b1;
              state_r <= RUN;
            end else begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IDXW{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign r    = r_r;
  assign z    = z_r;
  assign c    = c_r;
  assign s    = s_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16; checks v as well
// when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cin;
  logic [15:0] a, b;
  logic        busy, done, z, c, s;
  logic [15:0] r;
`ifdef ALU_SEQ_OVF_EN
  logic        v;
`endif

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .z     (z),
    .c     (c),
    .s     (s)
`ifdef ALU_SEQ_OVF_EN
    ,
    .v     (v)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after sampling, and check the result at E0+4
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ic, input logic [15:0] er,
                        input logic ez, input logic ec, input logic es, input logic ev);
    op = o; a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; a = ~ia; b = 16'h5A5A; cin = ~ic;
    check({tag, ".busy_e0"}, {15'd0, busy}, 16'd1);
    repeat (3) begin
      tick();
      check({tag, ".done_early"}, {15'd0, done}, 16'd0);
    end
    tick();
    check({tag, ".done"}, {15'd0, done}, 16'd1);
    check({tag, ".busy_end"}, {15'd0, busy}, 16'd0);
    check({tag, ".r"}, r, er);
    check({tag, ".z"}, {15'd0, z}, {15'd0, ez});
    check({tag, ".c"}, {15'd0, c}, {15'd0, ec});
    check({tag, ".s"}, {15'd0, s}, {15'd0, es});
`ifdef ALU_SEQ_OVF_EN
    check({tag, ".v"}, {15'd0, v}, {15'd0, ev});
`endif
    tick();
    check({tag, ".done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  int extra;

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; cin = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (2) tick();
    check("rst.busy", {15'd0, busy}, 16'd0);
    check("rst.done", {15'd0, done}, 16'd0);
    check("rst.r", r, 16'h0000);
    check("rst.flags", {13'd0, z, c, s}, 16'd0);
    reset = 1'b0;
    tick();

    run_op("add_ff", 3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("nega1", 3'b010, 16'h0001, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("nega0", 3'b010, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("negb2", 3'b011, 16'h0000, 16'h0002, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("xor", 3'b110, 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("and", 3'b100, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Held start: second op latched on the completing edge, done every 4 cycles
    op = 3'b000; a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h0005; b = 16'h0005;
    repeat (3) begin
      tick();
      check("b2b.done_mid1", {15'd0, done}, 16'd0);
    end
    tick();
    check("b2b.done1", {15'd0, done}, 16'd1);
    check("b2b.r1", r, 16'h0002);
    check("b2b.busy1", {15'd0, busy}, 16'd1);
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (3) begin
      tick();
      check("b2b.done_mid2", {15'd0, done}, 16'd0);
    end
    tick();
    check("b2b.done2", {15'd0, done}, 16'd1);
    check("b2b.r2", r, 16'h000A);
    check("b2b.busy2", {15'd0, busy}, 16'd0);

    // Start pulse while busy is ignored
    op = 3'b000; a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ign.r_hold", r, 16'h000A);
    tick();
    check("ign.done", {15'd0, done}, 16'd1);
    check("ign.r", r, 16'h0030);
    extra = 0;
    repeat (6) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    check("ign.no_extra", extra[15:0], 16'd0);

    run_op("inc", 3'b001, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset two cycles into an operation
    op = 3'b000; a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid.busy_pre", {15'd0, busy}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("mid.busy", {15'd0, busy}, 16'd0);
    check("mid.done", {15'd0, done}, 16'd0);
    check("mid.r", r, 16'h0000);
    check("mid.flags", {13'd0, z, c, s}, 16'd0);
    tick();
    reset = 1'b0;
    extra = 0;
    repeat (6) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    check("mid.no_done", extra[15:0], 16'd0);

    run_op("add_3_4", 3'b000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
